uart_tx_arbiter: RTL

//  Round-robin arbiter sharing the single UART0 transmit byte stream (feeding tx0) between
//  NUM_REQ byte producers, e.g. the CPU MMIO port, a trap/debug reporter and a DMA.

---
 rtl/uart_tx_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter merging NUM_REQ byte producers onto the
// single UART0 transmit byte stream, with a one-entry registered output stage.
// Optional feature macro: UART_ARB_LOCK_EN -- when defined, a requester that
// starts a message keeps the grant until it sends a byte flagged req_last.
module uart_tx_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = 8,
    localparam int SRC_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    input  logic                      out_ready,
    output logic                      busy
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [SRC_W-1:0]   rr_ptr;
    logic               can_load;
    logic               grant_found;
    logic [SRC_W-1:0]   grant_idx;
    logic [DATA_W-1:0]  grant_data;
    logic               load;
    logic [SRC_W-1:0]   scan;
    int                 scan_sum;
    logic               locked;

    // Next round-robin position after idx, wrapping at NUM_REQ-1.
    function automatic logic [SRC_W-1:0] ptr_inc(input logic [SRC_W-1:0] idx);
        if (idx == SRC_W'(NUM_REQ - 1)) return '0;
        return idx + SRC_W'(1);
    endfunction

`ifdef UART_ARB_LOCK_EN
    logic [SRC_W-1:0] lock_id;

    // Track the message owner: lock on a non-last byte, release on its last byte.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of block ordering.
        if (reset) begin
            locked  <= 1'b0;
            lock_id <= '0;
        end else if (load) begin
            if (locked) begin
                if (req_last[lock_id]) locked <= 1'b0;
            end else if (!req_last[grant_idx]) begin
                locked  <= 1'b1;
                lock_id <= grant_idx;
            end
        end
    end
`else
    // Per-byte arbitration only; there is never a message owner.
    assign locked = 1'b0;
`endif

    // The output register can take a new byte when empty or being drained.
    assign can_load = !out_valid || out_ready;

    // Pick the first valid requester at or after rr_ptr, or the lock owner.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the block leaves a value held and no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        scan        = '0;
        scan_sum    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_sum = int'(rr_ptr) + k;
            if (scan_sum >= NUM_REQ) scan_sum = scan_sum - NUM_REQ;
            scan = SRC_W'(scan_sum);
            if (!grant_found && req_valid[scan]) begin
                grant_found = 1'b1;
                grant_idx   = scan;
            end
        end
`ifdef UART_ARB_LOCK_EN
        if (locked) begin
            grant_found = req_valid[lock_id];
            grant_idx   = lock_id;
        end
`endif
    end

    // Select the winner's byte and raise its one-hot ready.
    always_comb begin
        grant_data = '0;
        req_ready  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == SRC_W'(i)) grant_data = req_data[i*DATA_W +: DATA_W];
        end
        if (load) req_ready[grant_idx] = 1'b1;
    end

    assign load = grant_found && can_load && !reset;

    // Capture the accepted byte and its source; hold while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data <= '0;
            out_src  <= '0;
        end else if (load) begin
            out_data <= grant_data;
            out_src  <= grant_idx;
        end
    end

    // Advance the fairness pointer past the winner, frozen inside a locked message.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (load && (!locked || req_last[grant_idx])) begin
            rr_ptr <= ptr_inc(grant_idx);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM next state: SEND while the output register holds a byte.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (load) state_next = SEND;
            SEND:    if (out_ready && !load) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        out_valid = (state == SEND);
        busy      = (state == SEND) || locked;
    end

endmodule
